// File: rtl/bldc_pkg.sv
`default_nettype none
// ==== bldc_pkg : phase encoding, sector constants and commutation tables ==== rev 1.0
package bldc_pkg;

  typedef enum logic [1:0] {
    PH_OFF = 2'b00,
    PH_HI  = 2'b01,
    PH_LO  = 2'b10
  } phase_e;

  localparam logic [2:0] SECTOR_NONE = 3'd0;
  localparam logic [2:0] SECTOR_MAX  = 3'd6;

  localparam int FAULT_HALL  = 0;
  localparam int FAULT_STALL = 1;

  localparam logic [1:0] PHASE_A = 2'd0;
  localparam logic [1:0] PHASE_B = 2'd1;
  localparam logic [1:0] PHASE_C = 2'd2;

  // Entry i describes sector i+1; the rows give the forward-direction drive.
  localparam logic [5:0][2:0] HALL_CODE =
    {3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
  localparam logic [5:0][1:0] HI_PHASE =
    {PHASE_C, PHASE_C, PHASE_B, PHASE_B, PHASE_A, PHASE_A};
  localparam logic [5:0][1:0] LO_PHASE =
    {PHASE_B, PHASE_A, PHASE_A, PHASE_C, PHASE_C, PHASE_B};

  function automatic logic [2:0] hall_to_sector(input logic [2:0] code);
    logic [2:0] sec;
    sec = SECTOR_NONE;
    for (int i = 0; i < 6; i++) begin
      if (HALL_CODE[i[2:0]] == code) sec = 3'(i + 1);
    end
    return sec;
  endfunction

  function automatic phase_e phase_request(input logic [2:0] sector,
                                           input logic       dir,
                                           input logic [1:0] phase);
    phase_e     req;
    logic [2:0] idx;
    req = PH_OFF;
    idx = sector - 3'd1;
    if (sector != SECTOR_NONE && sector <= SECTOR_MAX) begin
      if (HI_PHASE[idx] == phase)      req = dir ? PH_LO : PH_HI;
      else if (LO_PHASE[idx] == phase) req = dir ? PH_HI : PH_LO;
    end
    return req;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bldc_phase_deadtime.sv
`default_nettype none
// ==== bldc_phase_deadtime : one half-bridge OFF/HI/LO state with dead-time gate ==== rev 1.0
module bldc_phase_deadtime
  import bldc_pkg::*;
#(
  parameter int DEAD_CYCLES = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  phase_e req,
  output logic   hi,
  output logic   lo
);

  // The edge that first sees a new request counts as one dead cycle.
  localparam logic [3:0] DEAD_RELOAD = 4'(DEAD_CYCLES - 1);

  phase_e     state_q;
  phase_e     pend_q;
  logic [3:0] dead_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PH_OFF;
      pend_q  <= PH_OFF;
      dead_q  <= 4'd0;
    end else begin
      case (state_q)
        PH_HI, PH_LO: begin
          if (req != state_q) begin
            state_q <= PH_OFF;
            pend_q  <= req;
            dead_q  <= DEAD_RELOAD;
          end
        end
        default: begin
          if (req != pend_q) begin
            pend_q <= req;
            dead_q <= DEAD_RELOAD;
          end else if (dead_q != 4'd0) begin
            dead_q <= dead_q - 4'd1;
          end else if (req != PH_OFF) begin
            state_q <= req;
          end
        end
      endcase
    end
  end

  assign hi = (state_q == PH_HI);
  assign lo = (state_q == PH_LO);

endmodule
`default_nettype wire

// File: rtl/bldc_commutator_pwm.sv
`default_nettype none
// ==== bldc_commutator_pwm : six-step Hall commutator with PWM, dead time and faults ==== rev 1.0
module bldc_commutator_pwm
  import bldc_pkg::*;
#(
  parameter int PWM_W       = 8,
  parameter int DEAD_CYCLES = 4,
  parameter int STALL_W     = 20
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             DIR,
  input  logic [PWM_W-1:0] J,
  input  logic             H1,
  input  logic             H2,
  input  logic             H3,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             AA,
  output logic             BB,
  output logic             CC,
  output logic [2:0]       SECTOR,
  output logic [1:0]       FAULT
);

  localparam logic [PWM_W-1:0]   CNT_MAX   = {PWM_W{1'b1}};
  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

  logic [2:0]         hall_s1_q, hall_s1_d;
  logic [2:0]         hall_s2_q, hall_s2_d;
  logic [2:0]         sector_q, sector_d;
  logic [PWM_W-1:0]   cnt_q, cnt_d;
  logic [PWM_W-1:0]   duty_q, duty_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [1:0]         fault_q, fault_d;
  logic               pwm_on;
  phase_e             phase_req [3];
  logic [2:0]         hi_w, lo_w;

  always_comb begin
    hall_s1_d = {H3, H2, H1};
    hall_s2_d = hall_s1_q;
    sector_d  = hall_to_sector(hall_s2_q);

    cnt_d  = cnt_q + PWM_W'(1);
    duty_d = (cnt_q == CNT_MAX) ? J : duty_q;
    pwm_on = (cnt_q < duty_q);

    if (!EN || duty_q == '0 || sector_d != sector_q) stall_d = '0;
    else if (stall_q != STALL_MAX)                   stall_d = stall_q + STALL_W'(1);
    else                                             stall_d = stall_q;

    fault_d = fault_q;
    if (!EN) begin
      fault_d = 2'b00;
    end else begin
      if (sector_d == SECTOR_NONE) fault_d[FAULT_HALL] = 1'b1;
      if (stall_q == STALL_MAX && duty_q != '0) fault_d[FAULT_STALL] = 1'b1;
    end

    // A chopped-off high side is simply an OFF request to the phase FSM.
    for (int p = 0; p < 3; p++) begin
      phase_req[p] = phase_request(sector_q, DIR, p[1:0]);
      if (!EN || fault_q != 2'b00)                   phase_req[p] = PH_OFF;
      else if (phase_req[p] == PH_HI && !pwm_on)     phase_req[p] = PH_OFF;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hall_s1_q <= 3'b000;
      hall_s2_q <= 3'b000;
      sector_q  <= SECTOR_NONE;
      cnt_q     <= '0;
      duty_q    <= '0;
      stall_q   <= '0;
      fault_q   <= 2'b00;
    end else begin
      hall_s1_q <= hall_s1_d;
      hall_s2_q <= hall_s2_d;
      sector_q  <= sector_d;
      cnt_q     <= cnt_d;
      duty_q    <= duty_d;
      stall_q   <= stall_d;
      fault_q   <= fault_d;
    end
  end

  for (genvar p = 0; p < 3; p++) begin : g_phase
    bldc_phase_deadtime #(
      .DEAD_CYCLES(DEAD_CYCLES)
    ) u_phase (
      .clk(CLK),
      .rst(RST),
      .req(phase_req[p]),
      .hi (hi_w[p]),
      .lo (lo_w[p])
    );
  end

  assign {C, B, A}    = hi_w;
  assign {CC, BB, AA} = lo_w;
  assign SECTOR       = sector_q;
  assign FAULT        = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_bldc_commutator_pwm.sv
`default_nettype none
// ==== tb_bldc_commutator_pwm : vector tables, corner sequences and a streak-based reference model ==== rev 1.0
module tb_bldc_commutator_pwm;

  localparam int PWM_W   = 8;
  localparam int DEAD    = 4;
  localparam int STALL_W = 10;
  localparam int PERIOD  = 1 << PWM_W;
  localparam int SMAX    = (1 << STALL_W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] j   = 8'h00;
  logic       h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
  logic       a, b, c, aa, bb, cc;
  logic [2:0] sector;
  logic [1:0] fault;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  always #10 clk = ~clk;

  bldc_commutator_pwm #(
    .PWM_W(PWM_W), .DEAD_CYCLES(DEAD), .STALL_W(STALL_W)
  ) dut (
    .CLK(clk), .RST(rst), .EN(en), .DIR(dir), .J(j),
    .H1(h1), .H2(h2), .H3(h3),
    .A(a), .B(b), .C(c), .AA(aa), .BB(bb), .CC(cc),
    .SECTOR(sector), .FAULT(fault)
  );

  // ---------------- reference model ----------------
  function automatic int hall2sec(input logic [2:0] code);
    case (code)
      3'b101: return 1;
      3'b100: return 2;
      3'b110: return 3;
      3'b010: return 4;
      3'b011: return 5;
      3'b001: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] sec2hall(input int s);
    case (s)
      1: return 3'b101;
      2: return 3'b100;
      3: return 3'b110;
      4: return 3'b010;
      5: return 3'b011;
      default: return 3'b001;
    endcase
  endfunction

  // 0 = off, 1 = high side, 2 = low side; sectors pair up on the high phase
  function automatic int model_req(input int s, input logic d, input int p);
    int hi_p, lo_p;
    if (s < 1 || s > 6) return 0;
    hi_p = (s - 1) / 2;
    lo_p = (s / 2 + 1) % 3;
    if (p == hi_p) return d ? 2 : 1;
    if (p == lo_p) return d ? 1 : 2;
    return 0;
  endfunction

  logic [2:0] m_s1, m_s2;
  int         m_sector, m_cnt, m_duty, m_stall;
  logic [1:0] m_fault, m_nf;
  int         m_ph [3];
  int         m_run [3];
  int         m_prev [3];
  int         m_newsec, m_rq, m_nstall;
  logic       m_pwm;

  // A phase turns on only after its request has been the same for DEAD+1 edges.
  always @(posedge clk) begin
    if (rst) begin
      m_s1 = 3'b000; m_s2 = 3'b000;
      m_sector = 0; m_cnt = 0; m_duty = 0; m_stall = 0; m_fault = 2'b00;
      for (int p = 0; p < 3; p++) begin
        m_ph[p] = 0; m_run[p] = 0; m_prev[p] = 0;
      end
    end else begin
      m_newsec = hall2sec(m_s2);
      m_pwm    = (m_cnt < m_duty);
      for (int p = 0; p < 3; p++) begin
        m_rq = model_req(m_sector, dir, p);
        if (!en || m_fault != 2'b00) m_rq = 0;
        else if (m_rq == 1 && !m_pwm) m_rq = 0;
        m_run[p]  = (m_rq == m_prev[p]) ? ((m_run[p] < 1000) ? m_run[p] + 1 : 1000) : 1;
        m_prev[p] = m_rq;
        if (m_ph[p] != 0) begin
          if (m_rq != m_ph[p]) m_ph[p] = 0;
        end else if (m_rq != 0 && m_run[p] >= DEAD + 1) begin
          m_ph[p] = m_rq;
        end
      end
      if (!en || m_duty == 0 || m_newsec != m_sector) m_nstall = 0;
      else if (m_stall < SMAX) m_nstall = m_stall + 1;
      else m_nstall = m_stall;
      m_nf = m_fault;
      if (!en) m_nf = 2'b00;
      else begin
        if (m_newsec == 0) m_nf[0] = 1'b1;
        if (m_stall == SMAX && m_duty != 0) m_nf[1] = 1'b1;
      end
      if (m_cnt == PERIOD - 1) m_duty = int'(j);
      m_cnt    = (m_cnt + 1) % PERIOD;
      m_fault  = m_nf;
      m_stall  = m_nstall;
      m_sector = m_newsec;
      m_s2     = m_s1;
      m_s1     = {h3, h2, h1};
    end
  end

  always @(negedge clk) begin
    logic [10:0] act, exp;
    if (!rst && chk_on) begin
      exp = {m_ph[0] == 1, m_ph[1] == 1, m_ph[2] == 1,
             m_ph[0] == 2, m_ph[1] == 2, m_ph[2] == 2, 3'(m_sector), m_fault};
      act = {a, b, c, aa, bb, cc, sector, fault};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL model t=%0t: got {A,B,C,AA,BB,CC,SECTOR,FAULT}=%b expected %b", $time, act, exp);
      end
      n_tests++;
      if ((a & aa) | (b & bb) | (c & cc)) begin
        n_fail++;
        $display("FAIL shoot_through t=%0t: got hi=%b%b%b lo=%b%b%b expected no overlap", $time, a, b, c, aa, bb, cc);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cnt(input int v);
    int k;
    k = 0;
    while (m_cnt != v && k < 600) begin
      tick();
      k++;
    end
    if (m_cnt != v) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_cnt: got %0d expected %0d", m_cnt, v);
    end
  endtask

  task automatic set_hall(input logic [2:0] code);
    {h3, h2, h1} = code;
  endtask

  task automatic en_pulse();
    en = 1'b0;
    tick();
    en = 1'b1;
  endtask

  typedef struct {
    logic [2:0] code;
    int         sec;
  } hall_vec_t;

  typedef struct {
    logic [2:0] code;
    logic       d;
    logic [5:0] outs;   // {A,B,C,AA,BB,CC}
  } req_vec_t;

  hall_vec_t hall_tbl [8];
  req_vec_t  req_tbl  [12];

  int n_a, n_bb, n_ccx, n_gap, cur;

  initial begin
    hall_tbl = '{'{3'b001, 6}, '{3'b101, 1}, '{3'b100, 2}, '{3'b110, 3},
                 '{3'b010, 4}, '{3'b011, 5}, '{3'b000, 0}, '{3'b111, 0}};
    req_tbl  = '{'{3'b101, 1'b0, 6'b100_010}, '{3'b100, 1'b0, 6'b100_001},
                 '{3'b110, 1'b0, 6'b010_001}, '{3'b010, 1'b0, 6'b010_100},
                 '{3'b011, 1'b0, 6'b001_100}, '{3'b001, 1'b0, 6'b001_010},
                 '{3'b101, 1'b1, 6'b010_100}, '{3'b100, 1'b1, 6'b001_100},
                 '{3'b110, 1'b1, 6'b001_010}, '{3'b010, 1'b1, 6'b100_010},
                 '{3'b011, 1'b1, 6'b100_001}, '{3'b001, 1'b1, 6'b010_001}};

    rst = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {a, b, c, aa, bb, cc, sector, fault}, 0);
    rst    = 1'b0;
    chk_on = 1'b1;

    // Hall decode with the bridge disabled
    set_hall(3'b001);
    j = 8'hFF;
    repeat (300) tick();
    foreach (hall_tbl[i]) begin
      set_hall(hall_tbl[i].code);
      repeat (4) tick();
      check($sformatf("hall_decode_%b", hall_tbl[i].code), sector, hall_tbl[i].sec);
      check($sformatf("hall_off_%b", hall_tbl[i].code), {a, b, c, aa, bb, cc, fault}, 0);
    end

    // Commutation table in the middle of a near-full PWM period
    foreach (req_tbl[i]) begin
      en = 1'b0;
      set_hall(req_tbl[i].code);
      dir = req_tbl[i].d;
      repeat (4) tick();
      en = 1'b1;
      wait_cnt(0);
      wait_cnt(128);
      check($sformatf("drive_%b_dir%0d", req_tbl[i].code, req_tbl[i].d),
            {a, b, c, aa, bb, cc}, req_tbl[i].outs);
    end
    dir = 1'b0;

    // Hall rotation at 1 us steps
    en = 1'b0;
    set_hall(3'b001);
    j = 8'hAA;
    repeat (4) tick();
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_hall(hall_tbl[i].code);
      repeat (50) tick();
      check($sformatf("rotate_sector_%0d", i), sector, hall_tbl[i].sec);
    end

    // Sector 1 duty 170/256 loses DEAD cycles of lead
    set_hall(3'b101);
    en_pulse();
    wait_cnt(0);
    wait_cnt(0);
    n_a = 0; n_bb = 0; n_ccx = 0;
    for (int i = 0; i < PERIOD; i++) begin
      n_a  += a;
      n_bb += bb;
      n_ccx += c | cc;
      tick();
    end
    check("pwm_ontime_170", n_a, 170 - DEAD);
    check("pwm_bb_steady", n_bb, PERIOD);
    check("pwm_c_idle", n_ccx, 0);

    // Duty change mid-period only applies from the next wrap
    en_pulse();
    j = 8'h10;
    wait_cnt(0);
    n_a = 0;
    for (int i = 0; i < PERIOD; i++) begin
      n_a += a;
      if (i == 100) j = 8'hF0;
      tick();
    end
    check("duty_latch_old", n_a, 16 - DEAD);
    n_a = 0;
    for (int i = 0; i < PERIOD; i++) begin
      n_a += a;
      tick();
    end
    check("duty_latch_new", n_a, 240 - DEAD);

    // On-time not longer than dead time yields no high-side pulse
    en_pulse();
    j = 8'h03;
    wait_cnt(0);
    n_a = 0; n_bb = 0;
    for (int i = 0; i < PERIOD; i++) begin
      n_a  += a;
      n_bb += bb;
      tick();
    end
    check("short_duty_no_pulse", n_a, 0);
    check("short_duty_lo_steady", n_bb, PERIOD);

    // Direction reversal inside sector 1
    en_pulse();
    j = 8'hFF;
    wait_cnt(0);
    wait_cnt(50);
    check("dir_pre", {a, bb}, 2'b11);
    dir = 1'b1;
    tick();
    check("dir_drop", {a, bb, b, aa}, 4'b0000);
    n_gap = 1;
    while (!(b && aa) && n_gap < 20) begin
      tick();
      n_gap++;
    end
    check("dir_dead_gap", (n_gap >= DEAD + 1 && n_gap <= 10), 1);
    dir = 1'b0;

    // Invalid Hall fault: sticky until EN drops
    en_pulse();
    repeat (20) tick();
    set_hall(3'b111);
    repeat (3) tick();
    set_hall(3'b101);
    repeat (5) tick();
    check("hall_fault_set", fault, 2'b01);
    check("hall_fault_off", {a, b, c, aa, bb, cc}, 0);
    repeat (10) tick();
    check("hall_fault_sticky", fault, 2'b01);
    en = 1'b0;
    tick();
    check("hall_fault_clear", fault, 2'b00);
    en = 1'b1;
    repeat (12) tick();
    check("hall_fault_recover", bb, 1);

    // Stall detection and its suppression at zero duty
    j = 8'h40;
    en_pulse();
    repeat (1000) tick();
    check("stall_early", fault[1], 0);
    repeat (40) tick();
    check("stall_set", fault[1], 1);
    check("stall_off", {a, b, c, aa, bb, cc}, 0);
    j = 8'h00;
    wait_cnt(0);
    en_pulse();
    repeat (1100) tick();
    check("stall_zero_duty", fault, 2'b00);

    // Randomised operation against the model
    cur = 1;
    for (int seg = 0; seg < 30; seg++) begin
      int r;
      if ($urandom_range(0, 3) == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) dir = ~dir;
      j = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 8)) : 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      if (r == 0) begin
        set_hall($urandom_range(0, 1) ? 3'b000 : 3'b111);
        repeat ($urandom_range(1, 4)) tick();
      end else if (r <= 4) begin
        cur = (cur % 6) + 1;
      end else if (r <= 8) begin
        cur = (cur == 1) ? 6 : cur - 1;
      end
      set_hall(sec2hall(cur));
      repeat ($urandom_range(20, 120)) tick();
    end

    chk_on = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
